load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage front end for the RV32E core. It accepts load/store requests from execute over a valid/ready handshake and drives the byte-addressed `single_port_memory_group` port (`we`, `data_width`, `addr`, `write_data`). It tracks requests in flight across the memory's fixed read latency, then sign- or zero-extends the returned `read_data`. Results go to writeback, in order, through a response FIFO.

## Interface
- `MEM_LATENCY`, 2: edges from memory-port inputs being valid to `read_data` being valid.
- `FIFO_DEPTH`, 4: response FIFO entries; power of two, at least 2.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: execute presents a request.
- `req_ready` out 1: LSU accepts the request this cycle.
- `req_funct3` in 3: RV32 load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_store` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `mem_we` out 1: to memory `we`.
- `mem_width` out 2: to memory `data_width` (00 byte, 01 half, 10 word).
- `mem_addr` out 32: to memory `addr`.
- `mem_wdata` out 32: to memory `write_data`.
- `mem_rdata` in 32: from memory `read_data`, right-aligned.
- `resp_valid` out 1: a response is available to writeback.
- `resp_ready` in 1: writeback consumes the response.
- `resp_data` out 32: extended load data; 0 for stores.
- `resp_fault` out 1: misaligned access (see Configuration).

## Operation
- Accept occurs when `req_valid && req_ready`.
- `req_ready = (fifo_count + inflight_count) < FIFO_DEPTH`. It is combinational on registered counts only and never depends on `req_valid`.
- On an accept edge, the `mem_*` registers load:
  - `mem_width = funct3[1:0]`.
  - `mem_we = req_store`.
  - `mem_addr = req_addr`.
  - `mem_wdata = req_wdata`.
- On a non-accept edge, `mem_we` clears to 0; `mem_addr`, `mem_width` and `mem_wdata` hold.
- Each accepted request enters an in-flight shift pipeline of depth `MEM_LATENCY+1`. Each entry carries `valid`, `store`, `funct3` and `fault`.
- On the edge where an entry exits the pipeline, it is written into the FIFO with `mem_rdata` processed as follows:
  - Loads are extended per `funct3`:
    - B sign-extends bit 7.
    - BU zero-extends byte 0.
    - H sign-extends bit 15.
    - HU zero-extends bits 15:0.
    - W passes through.
  - Stores and faulted entries write `resp_data = 0`.
- Reserved `funct3` values (011, 110, 111) are treated as W.
- FIFO behaviour:
  - Order is first in, first out.
  - Head is presented on `resp_*`.
  - Pop on `resp_valid && resp_ready`.
  - Simultaneous push and pop: count unchanged.
  - Overflow cannot occur because of the credit rule above.
- Reset values:
  - `req_ready` = 1.
  - `mem_we` = 0.
  - `mem_width` = 00.
  - `mem_addr` = 0.
  - `mem_wdata` = 0.
  - `resp_valid` = 0.
  - `resp_data` = 0.
  - `resp_fault` = 0.
  - Pipeline and FIFO are empty.
- Reset mid-operation discards all in-flight entries and FIFO contents immediately. Memory writes already issued are not undone.

## Timing
- Request accepted at edge E0 → `mem_*` valid after E0.
- Memory returns `mem_rdata` valid after E0+`MEM_LATENCY`.
- The response is captured at E0+`MEM_LATENCY`+1. `resp_valid` is high after that edge, a latency of 3 cycles with defaults.
- Back-to-back accepts sustain one request per cycle while `resp_ready` stays high.
- With `resp_ready` held low, `req_ready` falls after `FIFO_DEPTH` accepts.
- A pop frees one credit on the same edge. `req_ready` rises in the following cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: the misalignment check is compiled in.
  - An access is misaligned when a halfword has `addr[0]=1`, or a word has `addr[1:0]!=0`.
  - A misaligned request is accepted normally but issues `mem_we=0`.
  - It returns `resp_fault=1` and `resp_data=0`, in order.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned addresses go to memory unchanged, since the memory handles unaligned byte addresses. `resp_fault` is tied 0.

## Test plan
- SW 0x77FF99AA to addr 0, then LW addr 0 → store response `resp_data=0`. After that, load response `resp_data=0x77FF99AA`, 3 cycles after its accept.
- With memory holding 0x77FF99AA at addr 0:
  - LB addr 1 → 0xFFFFFF99.
  - LBU addr 1 → 0x00000099.
  - LH addr 2 → 0x000077FF.
  - LHU addr 0 → 0x000099AA.
- Hold `resp_ready=0` and issue 6 back-to-back LW → 4 accepted, then `req_ready=0`. Raise `resp_ready` → all responses come out in issue order, and `req_ready` recovers.
- SH 0x1111 to addr 3:
  - With `LSU_MISALIGN_TRAP_EN`: `mem_we` stays 0 and the response has `resp_fault=1`.
  - Without it: `mem_we=1`, `mem_addr=3` and `resp_fault=0`.
- Assert `rst` while 2 loads are in flight and 1 response is queued → all outputs immediately take their reset values. No stale response appears after `rst` deasserts.
- Simultaneous push and pop with `FIFO_DEPTH-1` entries queued → count unchanged, no data lost or duplicated.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage front end for the RV32E core.
// Issues load/store requests to a fixed-latency byte-addressed memory port,
// tracks them in flight, extends returned load data and queues in-order
// responses for writeback.
// Optional feature: define LSU_MISALIGN_TRAP_EN to compile in misalignment faults.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_fault
);
  localparam int unsigned PL_DEPTH = MEM_LATENCY + 1;
  localparam int unsigned F3_W     = 3 * PL_DEPTH;
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + PL_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic                          w_accept;
  logic                          w_misalign;
  logic                          w_push;
  logic                          w_pop;
  logic [1:0]                    w_width;
  logic [31:0]                   w_ext;

  logic                          r_mem_we;
  logic [1:0]                    r_mem_width;
  logic [31:0]                   r_mem_addr;
  logic [31:0]                   r_mem_wdata;

  logic [PL_DEPTH-1:0]           r_pl_valid;
  logic [PL_DEPTH-1:0]           r_pl_store;
  logic [PL_DEPTH-1:0]           r_pl_fault;
  logic [PL_DEPTH-1:0][2:0]      r_pl_funct3;
  logic [CNT_W-1:0]              r_inflight;

  logic [31:0]                   r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]         r_fifo_fault;
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [CNT_W-1:0]              r_fifo_count;

  // Credit check uses registered counts only, independent of req_valid.
  assign req_ready = (r_fifo_count + r_inflight) < DEPTH_C;
  assign w_accept  = req_valid && req_ready;

  // Reserved funct3 encodings (x11) are issued as word accesses.
  assign w_width = (req_funct3[1:0] == 2'b11) ? 2'b10 : req_funct3[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((w_width == 2'b01) && req_addr[0]) ||
                      ((w_width == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Memory port registers: load on accept, write enable is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_width <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_mem_we    <= req_store && !w_misalign;
      r_mem_width <= w_width;
      r_mem_addr  <= req_addr;
      r_mem_wdata <= req_wdata;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_width = r_mem_width;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // In-flight shift pipeline spanning the memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pl_valid  <= '0;
      r_pl_store  <= '0;
      r_pl_fault  <= '0;
      r_pl_funct3 <= '0;
    end else begin
      r_pl_valid  <= (r_pl_valid << 1) | PL_DEPTH'(w_accept);
      r_pl_store  <= (r_pl_store << 1) | PL_DEPTH'(w_accept && req_store);
      r_pl_fault  <= (r_pl_fault << 1) | PL_DEPTH'(w_accept && w_misalign);
      r_pl_funct3 <= (r_pl_funct3 << 3) | F3_W'(req_funct3);
    end
  end

  assign w_push = r_pl_valid[MEM_LATENCY];
  assign w_pop  = resp_valid && resp_ready;

  // In-flight counter: +1 on accept, -1 when an entry leaves the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + ONE_C;
        2'b01:   r_inflight <= r_inflight - ONE_C;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Extend the returned data for the entry leaving the pipeline.
  always_comb begin
    w_ext = mem_rdata;
    case (r_pl_funct3[MEM_LATENCY])
      3'b000:  w_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b100:  w_ext = {24'h000000, mem_rdata[7:0]};
      3'b001:  w_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b101:  w_ext = {16'h0000, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
    if (r_pl_store[MEM_LATENCY] || r_pl_fault[MEM_LATENCY]) begin
      w_ext = '0;
    end
  end

  // Response FIFO control: pointers, occupancy and fault flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_fifo_fault <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
        r_fifo_fault[r_wr_ptr] <= r_pl_fault[MEM_LATENCY];
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + ONE_C;
        2'b01:   r_fifo_count <= r_fifo_count - ONE_C;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Response FIFO data storage; stale slots are masked at the output.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_ext;
    end
  end

  assign resp_valid = (r_fifo_count != '0);
  assign resp_data  = resp_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign resp_fault = resp_valid && r_fifo_fault[r_rd_ptr];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 2-cycle
// byte-addressed memory model attached to the mem_* port.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic        req_store = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault)
  );

  // Memory model: inputs registered, read data two edges later.
  logic [7:0]  mem [64];
  logic [31:0] rd1, rd2;
  assign mem_rdata = rd2;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata[7:0];
      if (mem_width != 2'b00) mem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
      if (mem_width[1]) begin
        mem[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
        mem[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
      end
    end
    case (mem_width)
      2'b00:   rd1 <= {24'h0, mem[mem_addr[5:0]]};
      2'b01:   rd1 <= {16'h0, mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]};
      default: rd1 <= {mem[mem_addr[5:0] + 6'd3], mem[mem_addr[5:0] + 6'd2],
                       mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]};
    endcase
    rd2 <= rd1;
  end

  // Present one request at a negedge, hold until accepted; returns at the negedge after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int waited;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    n_cmp++; if (mem_we !== 1'b0)      begin n_err++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    n_cmp++; if (mem_width !== 2'b00)  begin n_err++; $display("FAIL rst_mem_width: got %b want 00", mem_width); end
    n_cmp++; if (mem_addr !== 32'h0)   begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0)  begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'h0)  begin n_err++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    n_cmp++; if (resp_fault !== 1'b0)  begin n_err++; $display("FAIL rst_resp_fault: got %0b want 0", resp_fault); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load;
    logic [31:0] got_d [4];
    int          got_k [4];
    int          n;
    resp_ready = 1'b1;
    issue(1'b1, 3'b010, 32'h0, 32'h77FF99AA);
    n_cmp++; if (mem_we !== 1'b1)            begin n_err++; $display("FAIL sw_mem_we: got %0b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0)         begin n_err++; $display("FAIL sw_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_width !== 2'b10)        begin n_err++; $display("FAIL sw_mem_width: got %b want 10", mem_width); end
    n_cmp++; if (mem_wdata !== 32'h77FF99AA) begin n_err++; $display("FAIL sw_mem_wdata: got %h want 77ff99aa", mem_wdata); end
    issue(1'b0, 3'b010, 32'h0, 32'h0);
    n_cmp++; if (mem_we !== 1'b0)            begin n_err++; $display("FAIL lw_mem_we: got %0b want 0", mem_we); end
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid && n < 4) begin
        got_d[n] = resp_data; got_k[n] = k; n++;
      end
    end
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL sw_lw_count: got %0d want 2", n); end
    if (n >= 2) begin
      n_cmp++; if (got_k[0] !== 2 || got_d[0] !== 32'h0)
        begin n_err++; $display("FAIL sw_resp: got cycle %0d data %h want cycle 2 data 0", got_k[0], got_d[0]); end
      n_cmp++; if (got_k[1] !== 3 || got_d[1] !== 32'h77FF99AA)
        begin n_err++; $display("FAIL lw_resp: got cycle %0d data %h want cycle 3 data 77ff99aa", got_k[1], got_d[1]); end
    end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3 [4];
    logic [31:0] ad [4];
    logic [31:0] ex [4];
    int          k;
    f3[0] = 3'b000; ad[0] = 32'd1; ex[0] = 32'hFFFFFF99;
    f3[1] = 3'b100; ad[1] = 32'd1; ex[1] = 32'h00000099;
    f3[2] = 3'b001; ad[2] = 32'd2; ex[2] = 32'h000077FF;
    f3[3] = 3'b101; ad[3] = 32'd0; ex[3] = 32'h000099AA;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      k = 0;
      while (!resp_valid && k < 10) begin @(negedge clk); k++; end
      n_cmp++; if (resp_valid !== 1'b1 || resp_data !== ex[i] || resp_fault !== 1'b0)
        begin n_err++; $display("FAIL load_ext_%0d: got v=%0b data %h f=%0b want v=1 data %h f=0", i, resp_valid, resp_data, resp_fault, ex[i]); end
      n_cmp++; if (k !== 3) begin n_err++; $display("FAIL load_lat_%0d: got %0d want 3", i, k); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ex [6];
    int          acc, got;
    logic        rdy;
    resp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) issue(1'b1, 3'b010, 32'(i * 4), 32'hC0DE0000 + 32'(i * 4));
    repeat (6) @(negedge clk);
    ex[0] = 32'h77FF99AA;
    for (int i = 1; i < 6; i++) ex[i] = 32'hC0DE0000 + 32'(i * 4);
    resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 6) begin
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'(acc * 4); req_wdata = '0;
      end else req_valid = 1'b0;
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid) acc++;
      @(negedge clk);
    end
    n_cmp++; if (acc !== 4)          begin n_err++; $display("FAIL bp_accepts: got %0d want 4", acc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready: got %0b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== ex[0])
      begin n_err++; $display("FAIL bp_head: got v=%0b data %h want v=1 data %h", resp_valid, resp_data, ex[0]); end
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (acc < 6) begin
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'(acc * 4);
      end else req_valid = 1'b0;
      rdy = req_ready;
      if (resp_valid) begin
        n_cmp++; if (resp_data !== ex[got])
          begin n_err++; $display("FAIL bp_order_%0d: got %h want %h", got, resp_data, ex[got]); end
        got++;
      end
      @(posedge clk);
      if (rdy && req_valid) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (got !== 6)          begin n_err++; $display("FAIL bp_drained: got %0d want 6", got); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_recover: got %0b want 1", req_ready); end
  endtask

  task automatic test_push_pop;
    logic [31:0] ex [4];
    int          got;
    for (int i = 0; i < 4; i++) ex[i] = 32'hC0DE0000 + 32'((i + 2) * 4);
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'd4, 32'h0);
    issue(1'b0, 3'b010, 32'd8, 32'h0);
    issue(1'b0, 3'b010, 32'd12, 32'h0);
    repeat (5) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_data !== 32'hC0DE0004)
      begin n_err++; $display("FAIL pp_pre: got rdy=%0b data %h want rdy=1 data c0de0004", req_ready, resp_data); end
    issue(1'b0, 3'b010, 32'd16, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++; if (resp_data !== 32'hC0DE0008 || req_ready !== 1'b1)
      begin n_err++; $display("FAIL pp_same_edge: got data %h rdy=%0b want data c0de0008 rdy=1", resp_data, req_ready); end
    issue(1'b0, 3'b010, 32'd20, 32'h0);
    repeat (4) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL pp_full: got %0b want 0", req_ready); end
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) begin
        n_cmp++; if (got >= 4 || resp_data !== ex[got & 3])
          begin n_err++; $display("FAIL pp_order_%0d: got %h want %h", got, resp_data, ex[got & 3]); end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL pp_count: got %0d want 4", got); end
  endtask

  task automatic test_misalign;
    logic exp_we, exp_fault;
    int   k;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_we = 1'b0; exp_fault = 1'b1;
`else
    exp_we = 1'b1; exp_fault = 1'b0;
`endif
    resp_ready = 1'b1;
    issue(1'b1, 3'b001, 32'd3, 32'h00001111);
    n_cmp++; if (mem_we !== exp_we)   begin n_err++; $display("FAIL ma_mem_we: got %0b want %0b", mem_we, exp_we); end
    n_cmp++; if (mem_addr !== 32'd3 || mem_width !== 2'b01)
      begin n_err++; $display("FAIL ma_mem_port: got addr %h width %b want addr 3 width 01", mem_addr, mem_width); end
    k = 0;
    while (!resp_valid && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== exp_fault || resp_data !== 32'h0)
      begin n_err++; $display("FAIL ma_resp: got v=%0b f=%0b data %h want v=1 f=%0b data 0", resp_valid, resp_fault, resp_data, exp_fault); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    logic stale;
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'd4, 32'h0);
    @(negedge clk);
    issue(1'b0, 3'b010, 32'd8, 32'h0);
    issue(1'b0, 3'b010, 32'd12, 32'h0);
    n_cmp++; if (resp_valid !== 1'b1 || mem_addr !== 32'd12)
      begin n_err++; $display("FAIL mr_pre: got v=%0b addr %h want v=1 addr c", resp_valid, mem_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_fault !== 1'b0)
      begin n_err++; $display("FAIL mr_resp: got v=%0b data %h f=%0b want 0 0 0", resp_valid, resp_data, resp_fault); end
    n_cmp++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_width !== 2'b00 || mem_wdata !== 32'h0)
      begin n_err++; $display("FAIL mr_mem: got rdy=%0b we=%0b addr %h w=%b wd %h want 1 0 0 00 0", req_ready, mem_we, mem_addr, mem_width, mem_wdata); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL mr_stale: got resp_valid seen=%0b want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_extend();
    test_back_to_back();
    test_push_pop();
    test_misalign();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
